// File: rtl/smic_sram_pkg.sv
// Shared definitions for the SMIC single-port SRAM wrappers: the RMW state
// encoding, the lane-merge helper and the lane-divisibility check.
package smic_sram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } rmw_state_e;

    // Widest word the merge helper handles; callers zero-extend into it.
    localparam int MERGE_MAX_W = 512;

    // True when the word splits into an integer number of equal lanes.
    function automatic bit lanes_divide_evenly(input int dw, input int nl);
        return (nl > 0) && ((dw % nl) == 0);
    endfunction

    // Lane i of the result takes new_word when wen_n[i] is low, else old_word.
    // lw is the lane width and nl the lane count; bits past lw*nl pass old_word.
    function automatic logic [MERGE_MAX_W-1:0] lane_merge(
        input logic [MERGE_MAX_W-1:0] old_word,
        input logic [MERGE_MAX_W-1:0] new_word,
        input logic [MERGE_MAX_W-1:0] wen_n,
        input int                     lw,
        input int                     nl
    );
        logic [MERGE_MAX_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < MERGE_MAX_W; b++) begin
            if ((lw > 0) && (b < lw * nl) && !wen_n[b / lw]) begin
                merged[b] = new_word[b];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/smic_spsram_core.sv
// Behavioural whole-word-write single-port array. In silicon builds this is
// replaced by the foundry macro; only the output latch is reset.
module smic_spsram_core #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 50
) (
    input  logic                  CLK,
    input  logic                  RST_B,
    input  logic                  CEN,
    input  logic                  WEN,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Whole-word write when enabled with WEN low; contents are never reset.
    always_ff @(posedge CLK) begin
        if (!CEN && !WEN) begin
            mem[A] <= D;
        end
    end

    // Read latch: loads on an enabled read and otherwise holds its value.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            Q <= '0;
        end else if (!CEN && WEN) begin
            Q <= mem[A];
        end
    end

endmodule

// File: rtl/smic_spsram_rmw.sv
// Single-port SRAM wrapper with per-lane write masking on a whole-word-write
// array. Partial writes become a two-cycle read-modify-write; reads and full
// writes complete in one cycle.
// Optional macro SMIC_SPSRAM_OREG_EN adds an output register (read latency 2).
module smic_spsram_rmw
    import smic_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 50,
    parameter int WE_WIDTH   = 5
) (
    input  logic                  CLK,
    input  logic                  RST_B,
    input  logic                  CEN,
    input  logic [WE_WIDTH-1:0]   WEN,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  READY
);

    localparam int LW       = DATA_WIDTH / WE_WIDTH;
    localparam bit LANES_OK = lanes_divide_evenly(DATA_WIDTH, WE_WIDTH);

    generate
        if (!LANES_OK) begin : g_bad_lanes
            $error("smic_spsram_rmw: DATA_WIDTH must be a multiple of WE_WIDTH");
        end
    endgenerate

    rmw_state_e            state;
    logic [ADDR_WIDTH-1:0] a_hold;
    logic [DATA_WIDTH-1:0] d_hold;
    logic [WE_WIDTH-1:0]   wen_hold;

    logic                  wen_all1;
    logic                  wen_all0;
    logic                  core_cen;
    logic                  core_wen;
    logic [ADDR_WIDTH-1:0] core_a;
    logic [DATA_WIDTH-1:0] core_d;
    logic [DATA_WIDTH-1:0] core_q;
    logic [DATA_WIDTH-1:0] merged;

    assign wen_all1 = &WEN;
    assign wen_all0 = ~|WEN;
    assign READY    = (state == ST_IDLE) ? 1'b1 : 1'b0;

    // Old word from the RMW read combined with the held write lanes.
    assign merged = DATA_WIDTH'(lane_merge(MERGE_MAX_W'(core_q),
                                           MERGE_MAX_W'(d_hold),
                                           MERGE_MAX_W'(wen_hold),
                                           LW, WE_WIDTH));

    // RMW sequencer: a mixed-WEN request latches its operands and spends one
    // cycle in MERGE, during which new requests are refused.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state    <= ST_IDLE;
            a_hold   <= '0;
            d_hold   <= '0;
            wen_hold <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!CEN && !wen_all1 && !wen_all0) begin
                        state    <= ST_MERGE;
                        a_hold   <= A;
                        d_hold   <= D;
                        wen_hold <= WEN;
                    end
                end
                ST_MERGE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Array port steering: idle passes the request through (a partial write
    // issues a read), MERGE writes back the merged word at the held address.
    always_comb begin
        core_cen = 1'b1;
        core_wen = 1'b1;
        core_a   = A;
        core_d   = D;
        case (state)
            ST_IDLE: begin
                core_cen = CEN;
                core_wen = !wen_all0;
            end
            ST_MERGE: begin
                core_cen = 1'b0;
                core_wen = 1'b0;
                core_a   = a_hold;
                core_d   = merged;
            end
            default: begin
                core_cen = 1'b1;
            end
        endcase
    end

    smic_spsram_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .CLK   (CLK),
        .RST_B (RST_B),
        .CEN   (core_cen),
        .WEN   (core_wen),
        .A     (core_a),
        .D     (core_d),
        .Q     (core_q)
    );

`ifdef SMIC_SPSRAM_OREG_EN
    logic                  rd_pend;
    logic [DATA_WIDTH-1:0] q_oreg;

    // Output register loads once, in the cycle after each array read.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            rd_pend <= 1'b0;
            q_oreg  <= '0;
        end else begin
            rd_pend <= !core_cen && core_wen;
            if (rd_pend) begin
                q_oreg <= core_q;
            end
        end
    end

    assign Q = q_oreg;
`else
    assign Q = core_q;
`endif

    wen_known_a: assert property (@(posedge CLK) disable iff (!RST_B)
                                  (!CEN && READY) |-> !$isunknown(WEN));

endmodule

// File: tb/tb_smic_spsram_rmw.sv
// Directed and swept checks for smic_spsram_rmw. Honours SMIC_SPSRAM_OREG_EN
// for the read latency it expects.
module tb_smic_spsram_rmw;

    localparam int AW = 7;
    localparam int DW = 50;
    localparam int NW = 5;
    localparam int LW = DW / NW;
`ifdef SMIC_SPSRAM_OREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    logic          CLK = 1'b0;
    logic          RST_B;
    logic          CEN;
    logic [NW-1:0] WEN;
    logic [AW-1:0] A;
    logic [DW-1:0] D;
    logic [DW-1:0] Q;
    logic          READY;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] model [128];

    smic_spsram_rmw #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WE_WIDTH   (NW)
    ) dut (
        .CLK   (CLK),
        .RST_B (RST_B),
        .CEN   (CEN),
        .WEN   (WEN),
        .A     (A),
        .D     (D),
        .Q     (Q),
        .READY (READY)
    );

    // Free-running 100 MHz clock.
    always #5 CLK = ~CLK;

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic cen, input logic [NW-1:0] wen,
                                 input logic [AW-1:0] a, input logic [DW-1:0] d);
        CEN = cen;
        WEN = wen;
        A   = a;
        D   = d;
    endtask

    task automatic go_idle();
        applyStimulus(1'b1, '1, '0, '0);
    endtask

    task automatic full_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        applyStimulus(1'b0, '0, a, d);
        cycle();
        go_idle();
        model[a] = d;
    endtask

    task automatic read_word(input logic [AW-1:0] a, output logic [DW-1:0] q);
        applyStimulus(1'b0, '1, a, '0);
        cycle();
        go_idle();
        repeat (RD_LAT - 1) cycle();
        q = Q;
    endtask

    function automatic logic [DW-1:0] model_merge(input logic [DW-1:0] old_w,
                                                  input logic [DW-1:0] new_w,
                                                  input logic [NW-1:0] wen);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < NW; i++) begin
            if (!wen[i]) r[i*LW +: LW] = new_w[i*LW +: LW];
        end
        return r;
    endfunction

    task automatic test_reset();
        logic [DW-1:0] q;
        RST_B = 1'b0;
        go_idle();
        #3;
        tests_run++;
        if (READY !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready: got %b expected 1", READY);
        end
        tests_run++;
        if (Q !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_q: got %h expected 0", Q);
        end
        cycle();
        tests_run++;
        if (READY !== 1'b1 || Q !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_hold: got ready=%b q=%h expected ready=1 q=0", READY, Q);
        end
        #3;
        RST_B = 1'b1;
        cycle();
        full_write(7'h00, 50'h3_FFFF_FFFF_FFFF);
        read_word(7'h00, q);
        tests_run++;
        if (q !== 50'h3_FFFF_FFFF_FFFF) begin
            tests_failed++;
            $display("[TB] FAIL read_a00: got %h expected 3ffffffffffff", q);
        end
    endtask

    task automatic test_partial();
        logic [DW-1:0] q;
        full_write(7'h05, 50'h2_AAAA_AAAA_AAAA);
        applyStimulus(1'b0, 5'b11110, 7'h05, '0);
        cycle();
        go_idle();
        tests_run++;
        if (READY !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL partial_busy: got ready=%b expected 0", READY);
        end
        cycle();
        tests_run++;
        if (READY !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL partial_ready_back: got ready=%b expected 1", READY);
        end
        tests_run++;
        if (Q !== 50'h2_AAAA_AAAA_AAAA) begin
            tests_failed++;
            $display("[TB] FAIL partial_prewrite_q: got %h expected 2aaaaaaaaaaaa", Q);
        end
        read_word(7'h05, q);
        tests_run++;
        if (q !== 50'h2_AAAA_AAAA_A800) begin
            tests_failed++;
            $display("[TB] FAIL partial_merged: got %h expected 2aaaaaaaaa800", q);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] q;
        full_write(7'h10, 50'h0_1234_5678_9ABC);
        applyStimulus(1'b0, 5'b11110, 7'h10, 50'h3_FFFF_FFFF_FFFF);
        cycle();
        tests_run++;
        if (READY !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first_busy: got ready=%b expected 0", READY);
        end
        applyStimulus(1'b0, 5'b01111, 7'h10, '0);
        cycle();
        tests_run++;
        if (READY !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_ready_between: got ready=%b expected 1", READY);
        end
        cycle();
        go_idle();
        tests_run++;
        if (READY !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second_busy: got ready=%b expected 0", READY);
        end
        cycle();
        tests_run++;
        if (READY !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_done: got ready=%b expected 1", READY);
        end
        read_word(7'h10, q);
        tests_run++;
        if (q !== 50'h0_0034_5678_9BFF) begin
            tests_failed++;
            $display("[TB] FAIL b2b_merged: got %h expected 000345678 9bff", q);
        end
    endtask

    task automatic test_ignore_busy();
        logic [DW-1:0] q;
        full_write(7'h10, '0);
        full_write(7'h11, 50'h1_1111_1111_1111);
        applyStimulus(1'b0, 5'b11011, 7'h10, 50'h3_FFFF_FFFF_FFFF);
        cycle();
        applyStimulus(1'b0, 5'b00000, 7'h11, 50'h0_CAFE_F00D_BEEF);
        tests_run++;
        if (READY !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL busy_ready: got ready=%b expected 0", READY);
        end
        cycle();
        cycle();
        go_idle();
        tests_run++;
        if (READY !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL busy_accept_ready: got ready=%b expected 1", READY);
        end
        read_word(7'h10, q);
        tests_run++;
        if (q !== 50'h0_0000_3FF0_0000) begin
            tests_failed++;
            $display("[TB] FAIL busy_a10: got %h expected 3ff00000", q);
        end
        read_word(7'h11, q);
        tests_run++;
        if (q !== 50'h0_CAFE_F00D_BEEF) begin
            tests_failed++;
            $display("[TB] FAIL busy_a11: got %h expected cafef00dbeef", q);
        end
    endtask

    task automatic test_reset_merge();
        logic [DW-1:0] q;
        full_write(7'h20, 50'h1);
        applyStimulus(1'b0, 5'b11110, 7'h20, 50'h3_FFFF_FFFF_FFFF);
        cycle();
        go_idle();
        #1;
        RST_B = 1'b0;
        #1;
        tests_run++;
        if (READY !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rstmerge_ready: got ready=%b expected 1", READY);
        end
        tests_run++;
        if (Q !== '0) begin
            tests_failed++;
            $display("[TB] FAIL rstmerge_q: got %h expected 0", Q);
        end
        #2;
        RST_B = 1'b1;
        cycle();
        read_word(7'h20, q);
        tests_run++;
        if (q !== 50'h1) begin
            tests_failed++;
            $display("[TB] FAIL rstmerge_a20: got %h expected 1", q);
        end
    endtask

    task automatic test_sweep();
        logic [DW-1:0] q;
        logic [DW-1:0] q_before;
        logic [63:0]   r;
        logic [NW-1:0] wen;
        for (int a = 0; a < 128; a++) begin
            r = {$urandom, $urandom};
            full_write(AW'(a), r[DW-1:0]);
        end
        for (int a = 0; a < 128; a++) begin
            r   = {$urandom, $urandom};
            wen = NW'($urandom_range(0, 31));
            if (wen == '1) begin
                read_word(AW'(a), q);
                tests_run++;
                if (q !== model[a]) begin
                    tests_failed++;
                    $display("[TB] FAIL sweep_read a=%0d: got %h expected %h", a, q, model[a]);
                end
            end else if (wen == '0) begin
                full_write(AW'(a), r[DW-1:0]);
            end else begin
                applyStimulus(1'b0, wen, AW'(a), r[DW-1:0]);
                cycle();
                go_idle();
                cycle();
                tests_run++;
                if (Q !== model[a]) begin
                    tests_failed++;
                    $display("[TB] FAIL sweep_prewrite a=%0d: got %h expected %h", a, Q, model[a]);
                end
                model[a] = model_merge(model[a], r[DW-1:0], wen);
            end
        end
        q_before = Q;
        for (int i = 0; i < 20; i++) begin
            r = {$urandom, $urandom};
            applyStimulus(1'b1, (i % 2 == 0) ? '1 : '0, AW'($urandom_range(0, 127)), r[DW-1:0]);
            cycle();
        end
        go_idle();
        cycle();
        tests_run++;
        if (Q !== q_before) begin
            tests_failed++;
            $display("[TB] FAIL sweep_cen_hold_q: got %h expected %h", Q, q_before);
        end
        for (int a = 0; a < 128; a++) begin
            read_word(AW'(a), q);
            tests_run++;
            if (q !== model[a]) begin
                tests_failed++;
                $display("[TB] FAIL sweep_readback a=%0d: got %h expected %h", a, q, model[a]);
            end
        end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        RST_B = 1'b0;
        go_idle();
        test_reset();
        test_partial();
        test_back_to_back();
        test_ignore_busy();
        test_reset_merge();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
